seg7_scan_reader: RTL and testbench
===================================

SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

Interface
REQ-001 The module SHALL have parameter SETTLE, default 4, range 2..255: consecutive clk cycles AN/CX must be stable before capture.
REQ-002 The module SHALL have parameter NDIG, default 8: number of digit positions (AN width).
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 resetSW  input  1  reset, synchronous and active-high.
REQ-005 AN  input  8  digit anodes, active-low; bit i low selects digit i.
REQ-006 CX  input  8  segment cathodes, active-low; CX[7:1]=a..g, CX[0]=dp.
REQ-007 digits  output  32  captured hex value per position; digit i at [4i+3:4i].
REQ-008 digit_ok  output  8  bit i set when digits[i] holds a valid decoded hex value.
REQ-009 cap_pulse  output  1  one-cycle pulse on each capture.
REQ-010 cap_idx  output  3  position captured on the cap_pulse cycle.
REQ-011 frame_valid  output  1  one-cycle pulse when all NDIG positions have been captured since the last pulse.
REQ-012 err_pattern  output  1  one-cycle pulse when a stable capture holds an undecodable CX[7:1].
REQ-013 err_multi_an  output  1  one-cycle pulse when AN has been stable with more than one bit low for SETTLE cycles.

Function
REQ-014 AN and CX SHALL be registered once, then compared against the previous registered value each cycle.
REQ-015 A stability counter SHALL clear on any AN or CX change, otherwise increment and saturate at SETTLE.
REQ-016 If AN/CX become constant at posedge t, capture SHALL occur at posedge t+SETTLE+1; this includes the 1-cycle input register.
REQ-017 Only one capture per dwell SHALL occur; the next requires an AN or CX change and a fresh SETTLE.
REQ-018 AN=8'hFF (all digits off) SHALL be idle: no capture, no error.
REQ-019 Exactly one AN bit low: decode CX[7:1] and ignore dp; update digits[idx]; cap_pulse=1 and cap_idx=idx.
REQ-020 Decode table (CX[7:1] hex -> value): 01->0, 4F->1, 12->2, 06->3, 4C->4, 24->5, 20->6, 0F->7, 00->8, 04->9, 08->A, 60->b, 31->C, 42->d, 30->E, 38->F.
REQ-021 CX[7:1]=7F (blank) SHALL clear digit_ok[idx], leave digits[idx] unchanged, still count as captured, and raise no error.
REQ-022 Any other CX[7:1] SHALL clear digit_ok[idx], pulse err_pattern, still count the position as captured, and leave digits[idx] unchanged.
REQ-023 Two or more AN bits low at capture time SHALL pulse err_multi_an, with no capture and no mask update.
REQ-024 A seen-mask SHALL set bit idx on each capture; when it becomes all-ones, frame_valid SHALL pulse in the same cycle as that cap_pulse and the mask SHALL clear.
REQ-025 Re-capturing an already-seen position SHALL overwrite digits and digit_ok, and SHALL NOT advance frame completion.
REQ-026 Counter and mask arithmetic SHALL never wrap; the stability counter saturates.

Reset
REQ-027 While resetSW=1 at posedge clk: digits=0, digit_ok=0, cap_pulse=0, cap_idx=0, frame_valid=0, err_pattern=0, err_multi_an=0, seen-mask=0, stability counter=0, input registers=AN 8'hFF and CX 8'hFF.
REQ-028 Reset asserted mid-dwell SHALL abort the dwell; after release, a full SETTLE window SHALL be required before capture.

Structure
REQ-029 Package seg7_pkg SHALL hold the REQ-020 pattern constants, the blank pattern 7'h7F, and the SETTLE default; the segment driver SHALL share it.
REQ-030 Sub-module seg7_pattern_decode SHALL be purely combinational: CX[7:1] in; value[3:0], is_valid, and is_blank out.

Verification
REQ-031 AN=FE, CX=8'h03 held 10 cycles -> exactly one cap_pulse at cycle SETTLE+1, cap_idx=0, digits[3:0]=0, digit_ok[0]=1.
REQ-032 Scan AN=FE..7F with CX encoding 1..8, 6 cycles each -> 8 cap_pulses; frame_valid on the 8th; digits=32'h87654321; digit_ok=FF.
REQ-033 AN=FD, CX toggles every 3 cycles (SETTLE=4) -> no cap_pulse; then hold -> one capture.
REQ-034 AN=F5 held 6 cycles -> err_multi_an pulses once; no cap_pulse; mask unchanged.
REQ-035 AN=FB, CX[7:1]=7E -> err_pattern, digit_ok[2]=0; then CX[7:1]=7F -> no error, digit_ok[2]=0.
REQ-036 resetSW pulsed at dwell cycle 3 -> no capture until SETTLE+1 cycles after release; all outputs 0 during reset.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low a..g patterns for hex 0..F, the blank
// pattern and the default settle window, used by both the scan reader and the segment driver.
package seg7_pkg;

  localparam int SETTLE_DEFAULT = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_PAT [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    return SEG_PAT[value];
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational a..g pattern to hex value lookup; zero latency, no handshake.
// Patterns that are neither a hex glyph nor blank leave is_valid_o and is_blank_o low.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] value_o,
  output logic       is_valid_o,
  output logic       is_blank_o
);

  always_comb begin
    value_o    = '0;
    is_valid_o = 1'b0;
    is_blank_o = (seg_i == SEG_BLANK);
    for (int v = 0; v < 16; v++) begin
      if (seg_i == SEG_PAT[v]) begin
        value_o    = 4'(v);
        is_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers hex digits from a multiplexed active-low 7-seg scan; captures SETTLE+1 cycles
// after AN/CX go quiet (one cycle is the input register); free-running, no backpressure.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT,
  parameter int NDIG   = 8
) (
  input  logic                                   clk,
  input  logic                                   resetSW,
  input  logic [NDIG-1:0]                        AN,
  input  logic [7:0]                             CX,
  output logic [4*NDIG-1:0]                      digits,
  output logic [NDIG-1:0]                        digit_ok,
  output logic                                   cap_pulse,
  output logic [$clog2(NDIG > 1 ? NDIG : 2)-1:0] cap_idx,
  output logic                                   frame_valid,
  output logic                                   err_pattern,
  output logic                                   err_multi_an
);

  localparam int         IDXW      = $clog2(NDIG > 1 ? NDIG : 2);
  localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  logic [NDIG-1:0]   an1_q, an2_q;
  logic [7:0]        cx1_q, cx2_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [NDIG-1:0]   ok_q, ok_d;
  logic              cap_q, cap_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              frame_q, frame_d;
  logic              errp_q, errp_d;
  logic              errm_q, errm_d;

  logic              stable;
  logic              fire;
  int                sel_int;
  int                n_low;

  logic [3:0]        dec_value;
  logic              dec_valid;
  logic              dec_blank;

  seg7_pattern_decode u_decode (
    .seg_i      (cx1_q[7:1]),
    .value_o    (dec_value),
    .is_valid_o (dec_valid),
    .is_blank_o (dec_blank)
  );

  always_comb begin
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    digits_d = digits_q;
    ok_d     = ok_q;
    cap_d    = 1'b0;
    idx_d    = idx_q;
    frame_d  = 1'b0;
    errp_d   = 1'b0;
    errm_d   = 1'b0;

    // The two register stages hold this cycle's and last cycle's sample.
    stable = (an1_q == an2_q) && (cx1_q == cx2_q);
    if (!stable) begin
      cnt_d = '0;
    end else if (cnt_q != SETTLE_C) begin
      cnt_d = cnt_q + 8'd1;
    end
    // Firing only on the step into saturation gives one capture per dwell.
    fire = stable && (cnt_q == SETTLE_M1);

    sel_int = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an1_q[i]) sel_int = i;
    end
    n_low = $countones(~an1_q);

    if (fire) begin
      if (n_low > 1) begin
        errm_d = 1'b1;
      end else if (n_low == 1) begin
        cap_d = 1'b1;
        idx_d = IDXW'(sel_int);
        if (dec_valid) begin
          digits_d[4*sel_int +: 4] = dec_value;
          ok_d[sel_int]            = 1'b1;
        end else begin
          ok_d[sel_int] = 1'b0;
          errp_d        = !dec_blank;
        end
        seen_d[sel_int] = 1'b1;
        if (&seen_d) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetSW) begin
      an1_q    <= '1;
      an2_q    <= '1;
      cx1_q    <= 8'hFF;
      cx2_q    <= 8'hFF;
      cnt_q    <= '0;
      seen_q   <= '0;
      digits_q <= '0;
      ok_q     <= '0;
      cap_q    <= 1'b0;
      idx_q    <= '0;
      frame_q  <= 1'b0;
      errp_q   <= 1'b0;
      errm_q   <= 1'b0;
    end else begin
      an1_q    <= AN;
      an2_q    <= an1_q;
      cx1_q    <= CX;
      cx2_q    <= cx1_q;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      digits_q <= digits_d;
      ok_q     <= ok_d;
      cap_q    <= cap_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      errp_q   <= errp_d;
      errm_q   <= errm_d;
    end
  end

  assign digits       = digits_q;
  assign digit_ok     = ok_q;
  assign cap_pulse    = cap_q;
  assign cap_idx      = idx_q;
  assign frame_valid  = frame_q;
  assign err_pattern  = errp_q;
  assign err_multi_an = errm_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench: each dwell long enough to capture pushes an expected capture record;
// a negedge monitor logs what the reader actually produced.
module tb_seg7_scan_reader;

  localparam int SETTLE = 4;
  localparam int NDIG   = 8;

  logic        clk = 1'b0;
  logic        resetSW;
  logic [7:0]  AN;
  logic [7:0]  CX;
  logic [31:0] digits;
  logic [7:0]  digit_ok;
  logic        cap_pulse;
  logic [2:0]  cap_idx;
  logic        frame_valid;
  logic        err_pattern;
  logic        err_multi_an;

  seg7_scan_reader #(.SETTLE(SETTLE), .NDIG(NDIG)) dut (
    .clk          (clk),
    .resetSW      (resetSW),
    .AN           (AN),
    .CX           (CX),
    .digits       (digits),
    .digit_ok     (digit_ok),
    .cap_pulse    (cap_pulse),
    .cap_idx      (cap_idx),
    .frame_valid  (frame_valid),
    .err_pattern  (err_pattern),
    .err_multi_an (err_multi_an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] dig;
    logic [7:0]  ok;
    logic        fv;
    logic        errp;
    logic [31:0] cyc;
  } cap_t;

  cap_t exp_q[$];
  cap_t obs_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int multi_cnt = 0;
  int fv_cnt    = 0;

  logic [31:0] m_dig  = '0;
  logic [7:0]  m_ok   = '0;
  logic [7:0]  m_seen = '0;

  logic [6:0] tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                           7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cap_pulse) obs_q.push_back({cap_idx, digits, digit_ok, frame_valid, err_pattern, 32'(cyc)});
    if (err_multi_an) multi_cnt++;
    if (frame_valid) fv_cnt++;
  end

  // Reference model of one completed dwell, applied at the capture cycle cap_cyc.
  task automatic expect_dwell(input logic [7:0] an, input logic [7:0] cx, input int cap_cyc);
    int lows, idx, val;
    cap_t e;
    lows = $countones(~an);
    if (lows != 1) return;
    idx = 0;
    for (int i = 0; i < 8; i++) if (!an[i]) idx = i;
    val = -1;
    for (int v = 0; v < 16; v++) if (cx[7:1] == tab[v]) val = v;
    e.errp = 1'b0;
    if (val >= 0) begin
      m_dig[4*idx +: 4] = 4'(val);
      m_ok[idx] = 1'b1;
    end else begin
      m_ok[idx] = 1'b0;
      e.errp = (cx[7:1] != 7'h7F);
    end
    m_seen[idx] = 1'b1;
    e.fv = (m_seen == 8'hFF);
    if (e.fv) m_seen = '0;
    e.idx = 3'(idx);
    e.dig = m_dig;
    e.ok  = m_ok;
    e.cyc = 32'(cap_cyc);
    exp_q.push_back(e);
  endtask

  // Presents an/cx for exactly n sampling edges.
  task automatic hold(input logic [7:0] an, input logic [7:0] cx, input int n);
    @(posedge clk);
    #1;
    AN = an;
    CX = cx;
    if (n >= SETTLE + 1) expect_dwell(an, cx, cyc + SETTLE + 2);
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetSW = 1'b1;
    AN = 8'hFF;
    CX = 8'hFF;
    repeat (2) @(posedge clk);
    #1 resetSW = 1'b0;
    m_dig = '0;
    m_ok = '0;
    m_seen = '0;
  endtask

  task automatic test_reset();
    resetSW = 1'b1;
    AN = 8'hFE;
    CX = 8'h03;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (digits !== 32'h0) begin bad++; $display("FAIL reset_digits: got %h want 0", digits); end
    total++; if (digit_ok !== 8'h0) begin bad++; $display("FAIL reset_digit_ok: got %h want 0", digit_ok); end
    total++; if (cap_pulse !== 1'b0) begin bad++; $display("FAIL reset_cap_pulse: got %b want 0", cap_pulse); end
    total++; if (cap_idx !== 3'd0) begin bad++; $display("FAIL reset_cap_idx: got %0d want 0", cap_idx); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
    total++; if (err_pattern !== 1'b0) begin bad++; $display("FAIL reset_err_pattern: got %b want 0", err_pattern); end
    total++; if (err_multi_an !== 1'b0) begin bad++; $display("FAIL reset_err_multi_an: got %b want 0", err_multi_an); end
    @(posedge clk);
    #1 resetSW = 1'b0;
  endtask

  task automatic test_single_capture();
    cap_t e, o;
    do_reset();
    hold(8'hFE, 8'h03, 10);
    hold(8'hFF, 8'hFF, SETTLE + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL single: no capture, want idx=%0d at cyc %0d", e.idx, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL single: got idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d want idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d",
          o.idx, o.dig, o.ok, o.fv, o.errp, o.cyc, e.idx, e.dig, e.ok, e.fv, e.errp, e.cyc); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL single_extra: %0d extra captures, want 0", obs_q.size()); obs_q.delete(); end
    total++; if (digit_ok[0] !== 1'b1) begin bad++; $display("FAIL single_ok0: got %b want 1", digit_ok[0]); end
  endtask

  task automatic test_scan_frame();
    cap_t e, o;
    logic [7:0] an;
    int fv_base;
    do_reset();
    fv_base = fv_cnt;
    for (int i = 0; i < 8; i++) begin
      an = ~(8'h01 << i);
      hold(an, {tab[i+1], 1'b1}, 6);
    end
    hold(8'hFF, 8'hFF, SETTLE + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL scan: no capture, want idx=%0d at cyc %0d", e.idx, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL scan: got idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d want idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d",
          o.idx, o.dig, o.ok, o.fv, o.errp, o.cyc, e.idx, e.dig, e.ok, e.fv, e.errp, e.cyc); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL scan_extra: %0d extra captures, want 0", obs_q.size()); obs_q.delete(); end
    total++; if (digits !== 32'h87654321) begin bad++; $display("FAIL scan_digits: got %h want 87654321", digits); end
    total++; if (digit_ok !== 8'hFF) begin bad++; $display("FAIL scan_ok: got %h want ff", digit_ok); end
    total++; if (fv_cnt - fv_base != 1) begin bad++; $display("FAIL scan_frames: got %0d want 1", fv_cnt - fv_base); end
  endtask

  task automatic test_unstable();
    cap_t e, o;
    do_reset();
    for (int k = 0; k < 4; k++) hold(8'hFD, {tab[(k % 2 == 1) ? 5 : 3], 1'b1}, 3);
    hold(8'hFD, {tab[7], 1'b1}, 8);
    hold(8'hFF, 8'hFF, SETTLE + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL unstable: no capture, want idx=%0d at cyc %0d", e.idx, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL unstable: got idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d want idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d",
          o.idx, o.dig, o.ok, o.fv, o.errp, o.cyc, e.idx, e.dig, e.ok, e.fv, e.errp, e.cyc); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL unstable_extra: %0d extra captures, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_multi_an();
    cap_t e, o;
    int m_base;
    int order [7] = '{1, 2, 4, 5, 6, 7, 3};
    logic [7:0] an;
    do_reset();
    hold(8'hFE, {tab[1], 1'b1}, 6);
    m_base = multi_cnt;
    hold(8'hF5, {tab[2], 1'b1}, 6);
    hold(8'hFF, 8'hFF, SETTLE + 4);
    total++; if (multi_cnt - m_base != 1) begin bad++; $display("FAIL multi_err: got %0d pulses want 1", multi_cnt - m_base); end
    for (int i = 0; i < 7; i++) begin
      an = ~(8'h01 << order[i]);
      hold(an, {tab[order[i]], 1'b1}, SETTLE + 1);
    end
    hold(8'hFF, 8'hFF, SETTLE + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL multi: no capture, want idx=%0d at cyc %0d", e.idx, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL multi: got idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d want idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d",
          o.idx, o.dig, o.ok, o.fv, o.errp, o.cyc, e.idx, e.dig, e.ok, e.fv, e.errp, e.cyc); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL multi_extra: %0d extra captures, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_bad_pattern();
    cap_t e, o;
    do_reset();
    hold(8'hFB, {tab[9], 1'b1}, 6);
    hold(8'hFB, {7'h7E, 1'b1}, 6);
    hold(8'hFB, {7'h7F, 1'b0}, 6);
    hold(8'hFF, 8'hFF, SETTLE + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL pattern: no capture, want idx=%0d at cyc %0d", e.idx, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL pattern: got idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d want idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d",
          o.idx, o.dig, o.ok, o.fv, o.errp, o.cyc, e.idx, e.dig, e.ok, e.fv, e.errp, e.cyc); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL pattern_extra: %0d extra captures, want 0", obs_q.size()); obs_q.delete(); end
    total++; if (digit_ok[2] !== 1'b0) begin bad++; $display("FAIL pattern_ok2: got %b want 0", digit_ok[2]); end
  endtask

  task automatic test_reset_mid_dwell();
    cap_t e, o;
    int rel;
    do_reset();
    hold(8'hFE, {tab[5], 1'b1}, 6);
    @(posedge clk);
    #1;
    AN = 8'hFD;
    CX = {tab[4], 1'b1};
    repeat (2) @(posedge clk);
    #1 resetSW = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({digits, digit_ok, cap_pulse, cap_idx, frame_valid, err_pattern, err_multi_an} !== 46'h0) begin
      bad++;
      $display("FAIL midreset_zero: got dig=%h ok=%h cap=%b idx=%0d fv=%b ep=%b em=%b want all 0",
        digits, digit_ok, cap_pulse, cap_idx, frame_valid, err_pattern, err_multi_an);
    end
    @(posedge clk);
    #1 resetSW = 1'b0;
    rel = cyc;
    m_dig = '0;
    m_ok = '0;
    m_seen = '0;
    expect_dwell(8'hFD, {tab[4], 1'b1}, rel + SETTLE + 2);
    repeat (SETTLE + 4) @(posedge clk);
    hold(8'hFF, 8'hFF, SETTLE + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL midreset: no capture, want idx=%0d at cyc %0d", e.idx, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL midreset: got idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d want idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d",
          o.idx, o.dig, o.ok, o.fv, o.errp, o.cyc, e.idx, e.dig, e.ok, e.fv, e.errp, e.cyc); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL midreset_extra: %0d extra captures, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    cap_t e, o;
    logic [7:0] an;
    do_reset();
    hold(8'hFE, {tab[1], 1'b1}, SETTLE);
    hold(8'hFE, {tab[2], 1'b1}, SETTLE + 1);
    hold(8'hFD, {tab[3], 1'b1}, SETTLE + 1);
    hold(8'hFE, {tab[4], 1'b1}, SETTLE + 1);
    for (int i = 2; i < 8; i++) begin
      an = ~(8'h01 << i);
      hold(an, {tab[15 - i], 1'b0}, SETTLE + 1);
    end
    hold(8'hFF, 8'hFF, SETTLE + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL b2b: no capture, want idx=%0d at cyc %0d", e.idx, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL b2b: got idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d want idx=%0d dig=%h ok=%h fv=%b errp=%b cyc=%0d",
          o.idx, o.dig, o.ok, o.fv, o.errp, o.cyc, e.idx, e.dig, e.ok, e.fv, e.errp, e.cyc); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL b2b_extra: %0d extra captures, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_scan_frame();
    test_unstable();
    test_multi_an();
    test_bad_pattern();
    test_reset_mid_dwell();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
